// File: rtl/sport_rx_mc_if.sv
`default_nettype none
// ============================================================================
//  Module   : sport_rx_mc_if
//  Purpose  : Bundles the serial pins, frame configuration and receive-FIFO
//             core-side signals of the multichannel SPORT receiver.
//  Revision : 1.0 - initial release
// ============================================================================
interface sport_rx_mc_if #(
  parameter int DW    = 16,
  parameter int NCH   = 32,
  parameter int CHW   = 5,
  parameter int DEPTH = 4
);
  localparam int SLW = $clog2(DW);
  localparam int LW  = $clog2(DEPTH) + 1;

  // Serial side and frame configuration
  logic           SP_EN;
  logic           SCLK;
  logic           RFS;
  logic           RD;
  logic [SLW-1:0] SLEN;
  logic           SEXT;
  logic           MCE;
  logic [NCH-1:0] CH_MASK;

  // Core side of the receive FIFO
  logic           RX_RD;
  logic           OVF_CLR;
  logic [DW-1:0]  RX_DATA;
  logic [CHW-1:0] RX_CH;
  logic           RX_VALID;
  logic [LW-1:0]  RX_LVL;
  logic           OVF;
  logic           ISR;

  // Master: whoever drives the pins and reads the FIFO
  modport master (
    output SP_EN, SCLK, RFS, RD, SLEN, SEXT, MCE, CH_MASK, RX_RD, OVF_CLR,
    input  RX_DATA, RX_CH, RX_VALID, RX_LVL, OVF, ISR
  );

  // Slave: the receiver itself
  modport slave (
    input  SP_EN, SCLK, RFS, RD, SLEN, SEXT, MCE, CH_MASK, RX_RD, OVF_CLR,
    output RX_DATA, RX_CH, RX_VALID, RX_LVL, OVF, ISR
  );
endinterface
`default_nettype wire

// File: rtl/sport_rx_mc.sv
`default_nettype none
// ============================================================================
//  Module   : sport_rx_mc
//  Purpose  : Single-clock multichannel serial receiver. Oversamples SCLK in
//             the DSPCLK domain, frames words on RFS, deserialises MSB-first
//             words of 3..DW bits and queues {channel, data} in a small
//             fall-through FIFO with overflow flag and per-word interrupt.
//  Revision : 1.0 - initial release
// ============================================================================
module sport_rx_mc #(
  parameter int DW    = 16,
  parameter int NCH   = 32,
  parameter int CHW   = 5,
  parameter int DEPTH = 4
) (
  input  wire logic    DSPCLK,
  input  wire logic    RST,
  sport_rx_mc_if.slave bus
);
  localparam int SLW = $clog2(DW);
  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  // --------------------------------------------------------------------------
  // Synchronisers and edge detect
  // --------------------------------------------------------------------------
  logic [2:0] r_sclk_s;
  logic [1:0] r_rfs_s;
  logic [1:0] r_rd_s;
  logic       w_sclk_rise;
  logic       w_rfs_s;
  logic       w_rd_s;
  logic       w_sample;

  // Bring the asynchronous pins into DSPCLK; SCLK keeps one extra stage for edge detection
  always_ff @(posedge DSPCLK) begin
    if (RST) begin
      r_sclk_s <= '0;
      r_rfs_s  <= '0;
      r_rd_s   <= '0;
    end else begin
      r_sclk_s <= {r_sclk_s[1:0], bus.SCLK};
      r_rfs_s  <= {r_rfs_s[0], bus.RFS};
      r_rd_s   <= {r_rd_s[0], bus.RD};
    end
  end

  assign w_sclk_rise = r_sclk_s[1] & ~r_sclk_s[2];
  assign w_rfs_s     = r_rfs_s[1];
  assign w_rd_s      = r_rd_s[1];
  // A disabled port never samples, so nothing can be pushed while SP_EN is low
  assign w_sample    = w_sclk_rise & bus.SP_EN;

  // --------------------------------------------------------------------------
  // Framing FSM and deserialiser
  // --------------------------------------------------------------------------
  logic [0:0]     r_state;
  logic [0:0]     w_state_nxt;
  logic [SLW-1:0] r_bcnt;
  logic [CHW-1:0] r_chan;
  logic [DW-2:0]  r_shift;
  logic [SLW-1:0] r_slen;
  logic           r_sext;
  logic           r_mce;
  logic [NCH-1:0] r_mask;

  logic [SLW-1:0] w_slen_eff;
  logic           w_start;
  logic           w_word_done;
  logic           w_last_chan;
  logic           w_mask_bit;
  logic           w_push;
  logic [CHW-1:0] w_tag;
  logic [DW-1:0]  w_word_raw;
  logic [DW-1:0]  w_word_ext;
  logic           w_fill;

  // Words shorter than 3 bits are not supported; clamp the requested length
  assign w_slen_eff  = (bus.SLEN < SLW'(2)) ? SLW'(2) : bus.SLEN;
  assign w_start     = (r_state == S_IDLE) & w_sample & w_rfs_s;
  assign w_word_done = (r_state == S_SHIFT) & w_sample & (r_bcnt == '0);
  assign w_last_chan = (r_chan == CHW'(NCH - 1));
  // Last bit merged combinationally so the push lands on the edge that samples it
  assign w_word_raw  = {r_shift, w_rd_s};

  // Select the frame-latched receive-enable bit of the current channel
  always_comb begin
    w_mask_bit = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (CHW'(i) == r_chan) w_mask_bit = r_mask[i];
    end
  end

  // State register
  always_ff @(posedge DSPCLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state: start on framed rise, leave after the last word of the frame
  always_comb begin
    w_state_nxt = r_state;
    if (!bus.SP_EN) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_start) w_state_nxt = S_SHIFT;
        S_SHIFT: if (w_word_done && (!r_mce || w_last_chan)) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // FSM outputs: push strobe for completed, unmasked words and their channel tag
  always_comb begin
    w_push = w_word_done & (~r_mce | w_mask_bit);
    w_tag  = r_mce ? r_chan : '0;
  end

  // Bit/channel counters, shift register and per-frame configuration snapshot
  always_ff @(posedge DSPCLK) begin
    if (RST) begin
      r_bcnt  <= '0;
      r_chan  <= '0;
      r_shift <= '0;
      r_slen  <= SLW'(2);
      r_sext  <= 1'b0;
      r_mce   <= 1'b0;
      r_mask  <= '0;
    end else if (!bus.SP_EN) begin
      r_bcnt  <= '0;
      r_chan  <= '0;
      r_shift <= '0;
    end else if (w_start) begin
      r_shift <= (DW-1)'(w_rd_s);
      r_bcnt  <= w_slen_eff - SLW'(1);
      r_chan  <= '0;
      r_slen  <= w_slen_eff;
      r_sext  <= bus.SEXT;
      r_mce   <= bus.MCE;
      r_mask  <= bus.CH_MASK;
    end else if ((r_state == S_SHIFT) && w_sample) begin
      if (r_bcnt == '0) begin
        // Next word starts from a clean register; words are back-to-back
        r_shift <= '0;
        if (r_mce && !w_last_chan) begin
          r_chan <= r_chan + CHW'(1);
          r_bcnt <= r_slen;
        end else begin
          r_chan <= '0;
        end
      end else begin
        r_shift <= w_word_raw[DW-2:0];
        r_bcnt  <= r_bcnt - SLW'(1);
      end
    end
  end

  // Sign- or zero-extend above the word MSB (bit r_slen)
  always_comb begin
    w_fill     = 1'b0;
    w_word_ext = '0;
    for (int i = 0; i < DW; i++) begin
      if (SLW'(i) == r_slen) w_fill = r_sext & w_word_raw[i];
    end
    for (int i = 0; i < DW; i++) begin
      w_word_ext[i] = (SLW'(i) <= r_slen) ? w_word_raw[i] : w_fill;
    end
  end

  // --------------------------------------------------------------------------
  // Receive FIFO
  // --------------------------------------------------------------------------
  logic [CHW+DW-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wr;
  logic [AW:0]       r_rd;
  logic              r_ovf;
  logic              r_isr;
  logic [LW-1:0]     w_lvl;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_wr_en;
  logic              w_ovf_set;
  logic [CHW+DW-1:0] w_head;

  assign w_lvl     = r_wr - r_rd;
  assign w_empty   = (w_lvl == '0);
  assign w_full    = (w_lvl == LW'(DEPTH));
  assign w_pop     = bus.RX_RD & ~w_empty;
  // A pop on the same edge frees the slot, so a full FIFO can still accept
  assign w_wr_en   = w_push & (~w_full | w_pop);
  assign w_ovf_set = w_push & w_full & ~w_pop;
  assign w_head    = r_mem[r_rd[AW-1:0]];

  // Storage array; contents are don't-care until the write pointer covers them
  always_ff @(posedge DSPCLK) begin
    if (w_wr_en) r_mem[r_wr[AW-1:0]] <= {w_tag, w_word_ext};
  end

  // Pointers carry one extra bit so full and empty are distinguishable
  always_ff @(posedge DSPCLK) begin
    if (RST) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_wr_en) r_wr <= r_wr + LW'(1);
      if (w_pop)   r_rd <= r_rd + LW'(1);
    end
  end

  // Sticky overflow (set beats clear) and per-word interrupt pulse
  always_ff @(posedge DSPCLK) begin
    if (RST) begin
      r_ovf <= 1'b0;
      r_isr <= 1'b0;
    end else begin
      r_isr <= w_push;
      if (w_ovf_set)        r_ovf <= 1'b1;
      else if (bus.OVF_CLR) r_ovf <= 1'b0;
    end
  end

  assign bus.RX_DATA  = w_empty ? '0 : w_head[DW-1:0];
  assign bus.RX_CH    = w_empty ? '0 : w_head[CHW+DW-1:DW];
  assign bus.RX_VALID = ~w_empty;
  assign bus.RX_LVL   = w_lvl;
  assign bus.OVF      = r_ovf;
  assign bus.ISR      = r_isr;

endmodule
`default_nettype wire

// File: doc/sport_rx_mc.md
Name: sport_rx_mc

Overview:
- Parametrised successor of the SPORT receive controller: single-clock multichannel serial receiver.
- Oversamples the external serial clock in the DSPCLK domain and frames words on RFS.
- Deserialises up to DW-bit words, with a per-frame channel counter and per-channel receive mask.
- Queues {channel, data} in a DEPTH-entry receive FIFO read by the core, with overflow flag and per-word interrupt.

Parameters:
- DW, 16, maximum word width; RX_DATA width.
- NCH, 32, channels per multichannel frame (>=2).
- CHW, 5, channel tag width; must be >= clog2(NCH).
- DEPTH, 4, FIFO entries; power of two, >=2.

Ports:
- DSPCLK  in  1  core clock; all state is on the rising edge.
- RST  in  1  synchronous, active-high reset.
- SP_EN  in  1  port enable; low aborts reception.
- SCLK  in  1  raw serial clock, asynchronous.
- RFS  in  1  raw receive frame sync, asynchronous.
- RD  in  1  raw serial data, asynchronous.
- SLEN  in  clog2(DW)  word length minus 1.
- SEXT  in  1  1 = sign-extend word, 0 = zero-extend.
- MCE  in  1  multichannel mode enable.
- CH_MASK  in  NCH  per-channel receive enable (MCE=1 only).
- RX_RD  in  1  FIFO pop strobe.
- OVF_CLR  in  1  clears OVF.
- RX_DATA  out  DW  FIFO head data.
- RX_CH  out  CHW  FIFO head channel tag.
- RX_VALID  out  1  FIFO not empty.
- RX_LVL  out  clog2(DEPTH)+1  FIFO occupancy.
- OVF  out  1  sticky overflow flag.
- ISR  out  1  one-cycle pulse per word pushed.

Behaviour:
- Sync and edge detect:
  - SCLK, RFS and RD each pass through a 2-flop synchroniser; SCLK gets a third flop.
  - sclk_rise = s2 & !s3.
  - Bits and frame sync are sampled only on DSPCLK edges with sclk_rise=1.
  - SCLK period must be >= 4 DSPCLK.
- SLEN handling: effective SLEN = max(SLEN, 2), i.e. 3..DW bits. SLEN, SEXT, MCE and CH_MASK are sampled at frame start and held for the frame.
- FSM states: IDLE, SHIFT.
  - IDLE: on sclk_rise with RFS_s=1:
    - shift in the first bit (RD_s);
    - bcnt = SLEN-1, chan = 0;
    - go to SHIFT.
  - SHIFT: on each sclk_rise, shift in RD_s, MSB first. When bcnt = 0 the word is complete, else bcnt decrements.
  - On word complete:
    - push when (MCE=0) or CH_MASK[chan]=1;
    - if MCE=0, or chan = NCH-1, go to IDLE;
    - otherwise chan += 1, bcnt reloads to SLEN, stay in SHIFT. Words are contiguous, with no gap bit.
  - RFS_s=1 while in SHIFT is ignored (no resync mid-frame).
  - A new frame may start on the sclk_rise immediately after returning to IDLE.
- Word assembly:
  - The final bit is merged combinationally with the shift register, so the push occurs on the same DSPCLK edge that samples the last bit.
  - Bits above SLEN are filled with 0 (SEXT=0) or the word MSB (SEXT=1).
  - Tag = chan (always 0 when MCE=0).
- Latency: the push edge is 3 DSPCLK after the final SCLK rising pin edge. RX_VALID, RX_LVL and ISR update on that edge.
- FIFO behaviour:
  - Fall-through: RX_DATA and RX_CH reflect the head entry whenever RX_VALID=1; they read 0 when empty.
  - Pop when RX_RD=1 and not empty. RX_RD when empty is ignored.
  - Push and pop in the same cycle: both occur, level unchanged, including when full.
  - Push when full without pop: word dropped, FIFO unchanged, OVF set. ISR still pulses.
  - OVF is cleared by OVF_CLR. If a set and a clear coincide, the set wins.
- SP_EN=0:
  - FSM forced to IDLE; bcnt, chan and the shift register cleared; a partial word is discarded without a push.
  - FIFO contents and OVF are retained and pops still work.
- RST (sync):
  - FSM = IDLE, counters 0, FIFO empty, pointers 0, synchronisers 0.
  - Output reset values: RX_DATA 0, RX_CH 0, RX_VALID 0, RX_LVL 0, OVF 0, ISR 0.
  - RST mid-word aborts the word with no push.
- Pointers: DEPTH is a power of two, so read/write pointers wrap naturally; level = wr - rd with one extra bit.

Test Plan:
- MCE=0, SLEN=7, SEXT=1, frame of bits 0x9A MSB-first -> one push: RX_DATA=0xFF9A, RX_CH=0, ISR pulses once; SEXT=0 -> RX_DATA=0x009A.
- MCE=1, NCH=32, SLEN=15, CH_MASK=0x0000_0005, 32 contiguous words with word n = n -> exactly two pushes, {0,0x0000} then {2,0x0002}; FSM returns to IDLE after channel 31.
- No pops, 5 single-channel frames, DEPTH=4 -> RX_LVL=4, OVF=1, FIFO holds words 1-4; OVF_CLR -> OVF=0.
- FIFO full, RX_RD asserted on the push edge -> RX_LVL stays 4, head advances, OVF stays 0.
- SP_EN dropped after 5 bits of a 16-bit word, then re-enabled with a fresh frame -> no push from the aborted word; the next word is received correctly. RST mid-word -> all outputs 0.
- SLEN=0 -> 3-bit word received. RFS pulse during SHIFT -> ignored; word and channel boundaries unchanged.
